// File: rtl/btle_pkg.sv
// Shared state encodings, preamble values and advertising-channel helper
// used by the btle_tx sequencer.
package btle_pkg;

  typedef logic [3:0] btle_state_t;

  localparam btle_state_t ST_INIT_TAP   = 4'd0;
  localparam btle_state_t ST_INIT_TABLE = 4'd1;
  localparam btle_state_t ST_IDLE       = 4'd2;
  localparam btle_state_t ST_LOAD_PDU   = 4'd3;
  localparam btle_state_t ST_DRAIN      = 4'd4;
  localparam btle_state_t ST_CFG        = 4'd5;
  localparam btle_state_t ST_START      = 4'd6;
  localparam btle_state_t ST_WAIT_TX    = 4'd7;
  localparam btle_state_t ST_GAP        = 4'd8;

  localparam logic [7:0] PREAMBLE_ADV  = 8'hAA;
  localparam logic [7:0] PREAMBLE_DATA = 8'h55;

  localparam logic [5:0] ADV_CH_37 = 6'd37;
  localparam logic [5:0] ADV_CH_38 = 6'd38;
  localparam logic [5:0] ADV_CH_39 = 6'd39;

  function automatic logic [7:0] preamble_for(input logic [5:0] ch);
    if (ch == ADV_CH_37 || ch == ADV_CH_38 || ch == ADV_CH_39)
      return PREAMBLE_ADV;
    return PREAMBLE_DATA;
  endfunction

endpackage

// File: rtl/btle_tx_ctrl_rom_loader.sv
// Generic ROM-to-RAM copier: sweeps a ROM address 0..DEPTH-1 while enabled and
// presents each word one cycle after the ROM returns it, then holds the last write.
module btle_tx_ctrl_rom_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              swept,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;

  // Stage 0: issue ROM address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      swept    <= 1'b0;
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
    end else begin
      vld_p1  <= en && !swept;
      addr_p1 <= rom_addr;
      if (en && !swept) begin
        if (rom_addr == LAST)
          swept <= 1'b1;
        else
          rom_addr <= rom_addr + 1'b1;
      end
    end
  end

  // Stage 1: ROM data valid, register the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else if (vld_p1) begin
      wr_addr <= addr_p1;
      wr_data <= rom_data;
      if (addr_p1 == LAST)
        done <= 1'b1;
    end
  end

endmodule

// File: rtl/btle_tx_ctrl.sv
// Sequencer in front of btle_tx: table init, PDU load, start, inter-frame gap.
// Optional WAIT_TX watchdog with sticky err_timeout under BTLE_TX_CTRL_TIMEOUT_EN.
module btle_tx_ctrl import btle_pkg::*; #(
`ifdef BTLE_TX_CTRL_TIMEOUT_EN
  parameter int TX_TIMEOUT_CLK          = 65535,
`endif
  parameter int CRC_STATE_BIT_WIDTH     = 24,
  parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
  parameter int GAUSS_FILTER_BIT_WIDTH  = 16,
  parameter int NUM_TAP_GAUSS_FILTER    = 17,
  parameter int SIN_COS_ADDR_BIT_WIDTH  = 11,
  parameter int IQ_BIT_WIDTH            = 8,
  parameter int PDU_ADDR_BIT_WIDTH      = 6,
  parameter int IFS_CLK                 = 2400
) (
  input  logic                                clk,
  input  logic                                rst_n,
  output logic [3:0]                          tap_rom_addr,
  input  logic [GAUSS_FILTER_BIT_WIDTH-1:0]   tap_rom_data,
  output logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   table_rom_addr,
  input  logic [IQ_BIT_WIDTH-1:0]             cos_rom_data,
  input  logic [IQ_BIT_WIDTH-1:0]             sin_rom_data,
  output logic [3:0]                          gauss_filter_tap_index,
  output logic [GAUSS_FILTER_BIT_WIDTH-1:0]   gauss_filter_tap_value,
  output logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   cos_table_write_address,
  output logic [SIN_COS_ADDR_BIT_WIDTH-1:0]   sin_table_write_address,
  output logic [IQ_BIT_WIDTH-1:0]             cos_table_write_data,
  output logic [IQ_BIT_WIDTH-1:0]             sin_table_write_data,
  input  logic [7:0]                          pdu_s_data,
  input  logic                                pdu_s_valid,
  input  logic                                pdu_s_last,
  output logic                                pdu_s_ready,
  input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] cfg_channel_number,
  input  logic [CRC_STATE_BIT_WIDTH-1:0]      cfg_crc_init,
  input  logic [31:0]                         cfg_access_address,
  output logic [PDU_ADDR_BIT_WIDTH-1:0]       pdu_octet_mem_addr,
  output logic [7:0]                          pdu_octet_mem_data,
  output logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
  output logic                                channel_number_load,
  output logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init_bit,
  output logic                                crc_state_init_bit_load,
  output logic [31:0]                         access_address,
  output logic [7:0]                          preamble,
  output logic                                tx_start,
  input  logic                                iq_valid_last,
  output logic                                init_done,
  output logic                                busy,
  output logic                                tx_done,
  output logic                                err_overflow
`ifdef BTLE_TX_CTRL_TIMEOUT_EN
  ,
  output logic                                err_timeout
`endif
);

  localparam int NUM_TAP_LOAD = (NUM_TAP_GAUSS_FILTER + 1) / 2;
  localparam int TABLE_DEPTH  = 1 << SIN_COS_ADDR_BIT_WIDTH;
  localparam int CNT_W        = PDU_ADDR_BIT_WIDTH + 1;
  localparam logic [CNT_W-1:0] PDU_DEPTH = CNT_W'(1 << PDU_ADDR_BIT_WIDTH);
  localparam int GAP_W        = $clog2(IFS_CLK + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFS_CLK - 1);
`ifdef BTLE_TX_CTRL_TIMEOUT_EN
  localparam int TO_W         = $clog2(TX_TIMEOUT_CLK + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TX_TIMEOUT_CLK - 1);
  logic [TO_W-1:0] to_cnt;
`endif

  btle_state_t state;
  logic [CNT_W-1:0] count;
  logic [GAP_W-1:0] gap_cnt;
  logic tap_swept, tap_done, tab_swept, tab_done;
  logic [2*IQ_BIT_WIDTH-1:0] tab_wr_data;
  logic [SIN_COS_ADDR_BIT_WIDTH-1:0] tab_wr_addr;
  logic pdu_hs, pdu_overflow, cfg_latch;

  btle_tx_ctrl_rom_loader #(
    .ADDR_W (4),
    .DATA_W (GAUSS_FILTER_BIT_WIDTH),
    .DEPTH  (NUM_TAP_LOAD)
  ) u_tap_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (1'b1),
    .rom_data (tap_rom_data),
    .rom_addr (tap_rom_addr),
    .wr_addr  (gauss_filter_tap_index),
    .wr_data  (gauss_filter_tap_value),
    .swept    (tap_swept),
    .done     (tap_done)
  );

  // Table sweep starts as soon as the tap addresses are issued, overlapping the tap tail.
  btle_tx_ctrl_rom_loader #(
    .ADDR_W (SIN_COS_ADDR_BIT_WIDTH),
    .DATA_W (2 * IQ_BIT_WIDTH),
    .DEPTH  (TABLE_DEPTH)
  ) u_table_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tap_swept),
    .rom_data ({cos_rom_data, sin_rom_data}),
    .rom_addr (table_rom_addr),
    .wr_addr  (tab_wr_addr),
    .wr_data  (tab_wr_data),
    .swept    (tab_swept),
    .done     (tab_done)
  );

  assign cos_table_write_address = tab_wr_addr;
  assign sin_table_write_address = tab_wr_addr;
  assign cos_table_write_data    = tab_wr_data[2*IQ_BIT_WIDTH-1:IQ_BIT_WIDTH];
  assign sin_table_write_data    = tab_wr_data[IQ_BIT_WIDTH-1:0];

  assign pdu_s_ready = (state == ST_IDLE) || (state == ST_LOAD_PDU) || (state == ST_DRAIN);
  assign busy        = (state != ST_IDLE);
  assign channel_number_load     = (state == ST_CFG);
  assign crc_state_init_bit_load = (state == ST_CFG);
  assign tx_start    = (state == ST_START);

  assign pdu_hs       = pdu_s_valid && pdu_s_ready;
  assign pdu_overflow = (state == ST_LOAD_PDU) && (count == PDU_DEPTH);
  assign cfg_latch    = pdu_hs && pdu_s_last && !pdu_overflow &&
                        ((state == ST_IDLE) || (state == ST_LOAD_PDU));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      channel_number     <= '0;
      crc_state_init_bit <= '0;
      access_address     <= '0;
      preamble           <= PREAMBLE_DATA;
    end else if (cfg_latch) begin
      channel_number     <= cfg_channel_number;
      crc_state_init_bit <= cfg_crc_init;
      access_address     <= cfg_access_address;
      preamble           <= preamble_for(6'(cfg_channel_number));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_INIT_TAP;
      count              <= '0;
      gap_cnt            <= '0;
      pdu_octet_mem_addr <= '0;
      pdu_octet_mem_data <= '0;
      init_done          <= 1'b0;
      tx_done            <= 1'b0;
      err_overflow       <= 1'b0;
`ifdef BTLE_TX_CTRL_TIMEOUT_EN
      to_cnt             <= '0;
      err_timeout        <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_INIT_TAP:   if (tap_done) state <= ST_INIT_TABLE;
        ST_INIT_TABLE: if (tab_done && tab_swept) begin
          state     <= ST_IDLE;
          init_done <= 1'b1;
        end
        ST_IDLE: if (pdu_hs) begin
          pdu_octet_mem_addr <= '0;
          pdu_octet_mem_data <= pdu_s_data;
          count              <= CNT_W'(1);
          state              <= pdu_s_last ? ST_CFG : ST_LOAD_PDU;
        end
        ST_LOAD_PDU: if (pdu_hs) begin
          // A 65th octet is dropped; the rest of the frame is drained without transmitting.
          if (pdu_overflow) begin
            err_overflow <= 1'b1;
            state        <= pdu_s_last ? ST_IDLE : ST_DRAIN;
          end else begin
            pdu_octet_mem_addr <= count[PDU_ADDR_BIT_WIDTH-1:0];
            pdu_octet_mem_data <= pdu_s_data;
            count              <= count + 1'b1;
            if (pdu_s_last) state <= ST_CFG;
          end
        end
        ST_DRAIN: if (pdu_hs && pdu_s_last) state <= ST_IDLE;
        ST_CFG:   state <= ST_START;
        ST_START: begin
          state <= ST_WAIT_TX;
`ifdef BTLE_TX_CTRL_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        ST_WAIT_TX: begin
          if (iq_valid_last) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
            tx_done <= 1'b1;
          end
`ifdef BTLE_TX_CTRL_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            state       <= ST_GAP;
            gap_cnt     <= GAP_LOAD;
            err_timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= ST_IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= ST_INIT_TAP;
      endcase
    end
  end

endmodule

// File: tb/tb_btle_tx_ctrl.sv
// Scoreboard bench for btle_tx_ctrl: ROM models, change-detecting write monitors,
// and directed packet scenarios.
module tb_btle_tx_ctrl;

  logic        clk, rst_n;
  logic [3:0]  tap_rom_addr;
  logic [15:0] tap_rom_data;
  logic [10:0] table_rom_addr;
  logic [7:0]  cos_rom_data, sin_rom_data;
  logic [3:0]  gauss_filter_tap_index;
  logic [15:0] gauss_filter_tap_value;
  logic [10:0] cos_table_write_address, sin_table_write_address;
  logic [7:0]  cos_table_write_data, sin_table_write_data;
  logic [7:0]  pdu_s_data;
  logic        pdu_s_valid, pdu_s_last, pdu_s_ready;
  logic [5:0]  cfg_channel_number;
  logic [23:0] cfg_crc_init;
  logic [31:0] cfg_access_address;
  logic [5:0]  pdu_octet_mem_addr;
  logic [7:0]  pdu_octet_mem_data;
  logic [5:0]  channel_number;
  logic        channel_number_load;
  logic [23:0] crc_state_init_bit;
  logic        crc_state_init_bit_load;
  logic [31:0] access_address;
  logic [7:0]  preamble;
  logic        tx_start, iq_valid_last, init_done, busy, tx_done, err_overflow;
`ifdef BTLE_TX_CTRL_TIMEOUT_EN
  logic        err_timeout;
`endif

  btle_tx_ctrl #(
`ifdef BTLE_TX_CTRL_TIMEOUT_EN
    .TX_TIMEOUT_CLK (100),
`endif
    .IFS_CLK (2400)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .tap_rom_addr            (tap_rom_addr),
    .tap_rom_data            (tap_rom_data),
    .table_rom_addr          (table_rom_addr),
    .cos_rom_data            (cos_rom_data),
    .sin_rom_data            (sin_rom_data),
    .gauss_filter_tap_index  (gauss_filter_tap_index),
    .gauss_filter_tap_value  (gauss_filter_tap_value),
    .cos_table_write_address (cos_table_write_address),
    .sin_table_write_address (sin_table_write_address),
    .cos_table_write_data    (cos_table_write_data),
    .sin_table_write_data    (sin_table_write_data),
    .pdu_s_data              (pdu_s_data),
    .pdu_s_valid             (pdu_s_valid),
    .pdu_s_last              (pdu_s_last),
    .pdu_s_ready             (pdu_s_ready),
    .cfg_channel_number      (cfg_channel_number),
    .cfg_crc_init            (cfg_crc_init),
    .cfg_access_address      (cfg_access_address),
    .pdu_octet_mem_addr      (pdu_octet_mem_addr),
    .pdu_octet_mem_data      (pdu_octet_mem_data),
    .channel_number          (channel_number),
    .channel_number_load     (channel_number_load),
    .crc_state_init_bit      (crc_state_init_bit),
    .crc_state_init_bit_load (crc_state_init_bit_load),
    .access_address          (access_address),
    .preamble                (preamble),
    .tx_start                (tx_start),
    .iq_valid_last           (iq_valid_last),
    .init_done               (init_done),
    .busy                    (busy),
    .tx_done                 (tx_done),
    .err_overflow            (err_overflow)
`ifdef BTLE_TX_CTRL_TIMEOUT_EN
    ,
    .err_timeout             (err_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] tap_val(input logic [3:0] k);
    return 16'h1000 + {12'd0, k} * 16'h0111;
  endfunction
  function automatic logic [7:0] cos_val(input logic [10:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] sin_val(input logic [10:0] a);
    return a[10:3] ^ 8'hC3;
  endfunction

  // Synchronous ROMs with one cycle of read latency
  always @(posedge clk) begin
    tap_rom_data <= tap_val(tap_rom_addr);
    cos_rom_data <= cos_val(table_rom_addr);
    sin_rom_data <= sin_val(table_rom_addr);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [19:0] tap_q[$];
  logic [37:0] tab_q[$];
  logic [13:0] pdu_q[$];
  int cyc = 0, n_start = 0, n_chload = 0, n_crcload = 0, n_done = 0, ld_cyc = 0, st_cyc = 0;

  task automatic load_init_q();
    tap_q.delete();
    tab_q.delete();
    for (int k = 0; k < 9; k++) tap_q.push_back({4'(k), tap_val(4'(k))});
    for (int a = 0; a < 2048; a++)
      tab_q.push_back({11'(a), 11'(a), cos_val(11'(a)), sin_val(11'(a))});
  endtask

  // Write ports have no enable: a write is any change of the address/data pair.
  initial begin
    logic [19:0] prev_tap, cur_tap;
    logic [37:0] prev_tab, cur_tab;
    logic [13:0] prev_pdu, cur_pdu;
    forever begin
      @(negedge clk);
      cyc++;
      cur_tap = {gauss_filter_tap_index, gauss_filter_tap_value};
      cur_tab = {cos_table_write_address, sin_table_write_address,
                 cos_table_write_data, sin_table_write_data};
      cur_pdu = {pdu_octet_mem_addr, pdu_octet_mem_data};
      if (rst_n) begin
        if (cur_tap != prev_tap) begin
          if (tap_q.size() == 0) check("tap_extra_write", 64'(cur_tap), 64'(prev_tap));
          else check("tap_write", 64'(cur_tap), 64'(tap_q.pop_front()));
        end
        if (cur_tab != prev_tab) begin
          if (tab_q.size() == 0) check("table_extra_write", 64'(cur_tab), 64'(prev_tab));
          else check("table_write", 64'(cur_tab), 64'(tab_q.pop_front()));
        end
        if (cur_pdu != prev_pdu) begin
          if (pdu_q.size() == 0) check("pdu_extra_write", 64'(cur_pdu), 64'(prev_pdu));
          else check("pdu_write", 64'(cur_pdu), 64'(pdu_q.pop_front()));
        end
        if (tx_start) begin n_start++; st_cyc = cyc; end
        if (channel_number_load) begin n_chload++; ld_cyc = cyc; end
        if (crc_state_init_bit_load) n_crcload++;
        if (tx_done) n_done++;
      end
      prev_tap = cur_tap;
      prev_tab = cur_tab;
      prev_pdu = cur_pdu;
    end
  end

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, 64'((n >= 2058 && n <= 2060) ? 2059 : n), 64'd2059);
    #1;
    check({tag, "_tap_q_left"}, 64'(tap_q.size()), 64'd0);
    check({tag, "_tab_q_left"}, 64'(tab_q.size()), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic send_pdu(input int n, input logic [7:0] seed);
    int w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pdu_s_data  = seed + 8'(i);
      pdu_s_valid = 1'b1;
      pdu_s_last  = (i == n - 1);
      if (i < 64) pdu_q.push_back({6'(i), seed + 8'(i)});
      w = 0;
      while (!pdu_s_ready && w < 5000) begin
        @(negedge clk);
        w++;
      end
      check("pdu_ready", 64'(pdu_s_ready), 64'd1);
      @(posedge clk);
    end
    @(negedge clk);
    pdu_s_valid = 1'b0;
    pdu_s_last  = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int w = 0;
    while (!tx_start && w < 50) begin
      @(negedge clk);
      w++;
    end
    #1;
    check({tag, "_tx_start"}, 64'(tx_start), 64'd1);
  endtask

  task automatic pulse_iq();
    @(negedge clk);
    iq_valid_last = 1'b1;
    @(negedge clk);
    iq_valid_last = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!pdu_s_ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_ready_back"}, 64'(pdu_s_ready), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base_start, base_done, g;
    rst_n = 1'b0;
    pdu_s_data = '0; pdu_s_valid = 1'b0; pdu_s_last = 1'b0;
    cfg_channel_number = '0; cfg_crc_init = '0; cfg_access_address = '0;
    iq_valid_last = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_preamble", 64'(preamble), 64'h55);
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_init_done", 64'(init_done), 64'd0);
    check("rst_ready", 64'(pdu_s_ready), 64'd0);
    check("rst_outs", 64'({tx_start, tx_done, err_overflow, channel_number_load,
                           crc_state_init_bit_load, tap_rom_addr}), 64'd0);
    load_init_q();
    rst_n = 1'b1;
    wait_init("init");

    // 37-octet advertising PDU on channel 37
    cfg_channel_number = 6'd37; cfg_crc_init = 24'h555555; cfg_access_address = 32'h8E89BED6;
    base_start = n_start; base_done = n_done;
    send_pdu(37, 8'h11);
    wait_start("adv");
    check("adv_preamble", 64'(preamble), 64'hAA);
    check("adv_channel", 64'(channel_number), 64'd37);
    check("adv_crc", 64'(crc_state_init_bit), 64'h555555);
    check("adv_aa", 64'(access_address), 64'h8E89BED6);
    check("adv_load_pulses", 64'({n_chload, n_crcload}), {32'd1, 32'd1});
    check("adv_start_after_load", 64'(st_cyc - ld_cyc), 64'd1);
    check("adv_pdu_q_left", 64'(pdu_q.size()), 64'd0);
    repeat (5) @(negedge clk);
    check("wait_tx_ready", 64'(pdu_s_ready), 64'd0);
    check("wait_tx_busy", 64'(busy), 64'd1);
    pulse_iq();
    check("adv_tx_done", 64'(tx_done), 64'd1);
    pdu_s_valid = 1'b1; pdu_s_data = 8'hEE; pdu_s_last = 1'b0;
    g = 0;
    while (!pdu_s_ready && g < 3000) begin
      g++;
      @(negedge clk);
    end
    pdu_s_valid = 1'b0;
    check("gap_cycles", 64'(g), 64'd2400);
    check("adv_done_count", 64'(n_done - base_done), 64'd1);
    check("adv_start_count", 64'(n_start - base_start), 64'd1);

    // iq_valid_last outside WAIT_TX is ignored
    pulse_iq();
    repeat (2) @(negedge clk);
    check("idle_iq_ignored", 64'({busy, 8'(n_done - base_done)}), 64'({1'b0, 8'd1}));

    // Single-octet data-channel PDU
    cfg_channel_number = 6'd5; cfg_crc_init = 24'h123456; cfg_access_address = 32'hA5A5F00F;
    send_pdu(1, 8'h77);
    wait_start("data");
    check("data_preamble", 64'(preamble), 64'h55);
    check("data_channel", 64'(channel_number), 64'd5);
    check("data_crc", 64'(crc_state_init_bit), 64'h123456);
    check("data_pdu_q_left", 64'(pdu_q.size()), 64'd0);
    pulse_iq();
    wait_ready("data");

    // 70 octets: overflow after 64, drained, no transmission
    cfg_channel_number = 6'd38;
    base_start = n_start;
    send_pdu(70, 8'h21);
    repeat (3) @(negedge clk);
    #1;
    check("ovf_err", 64'(err_overflow), 64'd1);
    check("ovf_no_start", 64'(n_start - base_start), 64'd0);
    check("ovf_idle", 64'({busy, pdu_s_ready}), 64'b01);
    check("ovf_pdu_q_left", 64'(pdu_q.size()), 64'd0);
    check("ovf_cfg_kept", 64'({channel_number, preamble}), 64'({6'd5, 8'h55}));

    // Reset during WAIT_TX
    cfg_channel_number = 6'd39;
    send_pdu(3, 8'h31);
    wait_start("rst");
    check("rst_adv_preamble", 64'(preamble), 64'hAA);
    base_done = n_done;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd1);
    check("abort_flags", 64'({init_done, err_overflow, pdu_s_ready, tx_start}), 64'd0);
    check("abort_preamble", 64'(preamble), 64'h55);
    check("abort_cfg", 64'({channel_number, crc_state_init_bit, access_address}), 64'd0);
    check("abort_wr_ports", 64'({pdu_octet_mem_addr, gauss_filter_tap_index, cos_table_write_address}), 64'd0);
    load_init_q();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_init("reinit");
    pulse_iq();
    repeat (2) @(negedge clk);
    check("abort_no_tx_done", 64'(n_done - base_done), 64'd0);

`ifdef BTLE_TX_CTRL_TIMEOUT_EN
    // Watchdog: iq_valid_last never arrives
    cfg_channel_number = 6'd9;
    base_done = n_done;
    send_pdu(2, 8'h41);
    wait_start("to");
    g = 0;
    while (!err_timeout && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("to_cycles", 64'(g), 64'd101);
    check("to_gap_ready", 64'({busy, pdu_s_ready}), 64'b10);
    check("to_no_tx_done", 64'(n_done - base_done), 64'd0);
    wait_ready("to");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
